// File: rtl/fifo_async_pkg.sv
// Shared helpers for the width-converting async FIFO: sizing math and gray coding.
package fifo_async_pkg;

  localparam int unsigned GW = 32;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  function automatic int unsigned min_w(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

  function automatic int unsigned max_w(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic int unsigned depth_lanes(input int unsigned size_b, input int unsigned dw_n);
    return (size_b * 8) / dw_n;
  endfunction

  function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
    logic [GW-1:0] b;
    b = g;
    for (int unsigned i = 1; i < GW; i++) b = b ^ (g >> i);
    return b;
  endfunction

endpackage

// File: rtl/fifo_async_wc_gray_sync.sv
// Multi-flop synchroniser for a gray-coded pointer entering a new clock domain.
module fifo_gray_sync #(
  parameter int unsigned W      = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [STAGES-1:0][W-1:0] sync_q;
  logic [STAGES-1:0][W-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_async_wc.sv
// Dual-clock FIFO with power-of-two write/read width conversion via narrow-lane storage.
// Optional sticky overflow/underflow flags under macro FIFO_ASYNC_WC_ERR_EN.
module fifo_async_wc
  import fifo_async_pkg::*;
#(
  parameter int unsigned DW_W        = 64,
  parameter int unsigned DW_R        = 32,
  parameter int unsigned SIZE        = 2048,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                             clk_w,
  input  logic                             clk_r,
  input  logic                             rst_n,
  input  logic                             w_req,
  input  logic [DW_W-1:0]                  data_i,
  output logic                             full,
  input  logic                             r_req,
  output logic [DW_R-1:0]                  data_o,
  output logic                             empty,
  output logic [clog2(SIZE*8/DW_W):0]      w_cnt,
  output logic [clog2(SIZE*8/DW_R):0]      r_cnt
`ifdef FIFO_ASYNC_WC_ERR_EN
  ,
  output logic                             ovf,
  output logic                             udf
`endif
);

  localparam int unsigned DW_N    = min_w(DW_W, DW_R);
  localparam int unsigned RW      = DW_W / DW_N;
  localparam int unsigned RR      = DW_R / DW_N;
  localparam int unsigned LOG_RW  = clog2(RW);
  localparam int unsigned LOG_RR  = clog2(RR);
  localparam int unsigned LOG_C   = clog2(max_w(RW, RR));
  localparam int unsigned DEPTH_N = depth_lanes(SIZE, DW_N);
  localparam int unsigned AW      = clog2(DEPTH_N);
  localparam int unsigned PW      = AW + 1;
  localparam int unsigned CW      = PW - LOG_C;
  localparam int unsigned WCW     = PW - LOG_RW;
  localparam int unsigned RCW     = PW - LOG_RR;

  // ---------------- write domain ----------------
  logic [PW-1:0]  wptr_q, wptr_d;
  logic [CW-1:0]  wgray_q, wgray_d;
  logic           full_q, full_d;
  logic [WCW-1:0] w_cnt_q, w_cnt_d;
  logic [CW-1:0]  rgray_sync;
  logic [PW-1:0]  rptr_sync_lanes;
  logic [PW-1:0]  w_used;
  logic           push_c;

  always_comb begin
    push_c          = w_req && !full_q;
    wptr_d          = push_c ? wptr_q + PW'(RW) : wptr_q;
    wgray_d         = CW'(bin2gray(GW'(wptr_d >> LOG_C)));
    rptr_sync_lanes = PW'(CW'(gray2bin(GW'(rgray_sync)))) << LOG_C;
    w_used          = wptr_d - rptr_sync_lanes;
    full_d          = (PW'(DEPTH_N) - w_used) < PW'(RW);
    w_cnt_d         = WCW'(w_used >> LOG_RW);
  end

  always_ff @(posedge clk_w) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      wgray_q <= '0;
      full_q  <= 1'b0;
      w_cnt_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      wgray_q <= wgray_d;
      full_q  <= full_d;
      w_cnt_q <= w_cnt_d;
    end
  end

  // Each lane owns its flops; a push writes the RW lanes of the current write group.
  logic [DW_N-1:0] lanes [DEPTH_N];

  for (genvar j = 0; j < DEPTH_N; j++) begin : g_lane
    localparam int unsigned OFF = (j % RW) * DW_N;
    logic [DW_N-1:0] lane_q;
    logic            lane_we_c;

    assign lane_we_c = rst_n && push_c &&
                       ((wptr_q[AW-1:0] >> LOG_RW) == AW'(j >> LOG_RW));

    always_ff @(posedge clk_w) begin
      if (lane_we_c) lane_q <= data_i[OFF +: DW_N];
    end

    assign lanes[j] = lane_q;
  end

  // ---------------- read domain ----------------
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   rgray_q, rgray_d;
  logic            empty_q, empty_d;
  logic [RCW-1:0]  r_cnt_q, r_cnt_d;
  logic [DW_R-1:0] data_o_q, data_o_d;
  logic [DW_R-1:0] rd_word_c;
  logic [CW-1:0]   wgray_sync;
  logic [PW-1:0]   wptr_sync_lanes;
  logic [PW-1:0]   r_avail;
  logic            pop_c;

  always_comb begin
    for (int unsigned i = 0; i < RR; i++) begin
      rd_word_c[i*DW_N +: DW_N] = lanes[rptr_q[AW-1:0] + AW'(i)];
    end
  end

  always_comb begin
    pop_c           = r_req && !empty_q;
    rptr_d          = pop_c ? rptr_q + PW'(RR) : rptr_q;
    rgray_d         = CW'(bin2gray(GW'(rptr_d >> LOG_C)));
    wptr_sync_lanes = PW'(CW'(gray2bin(GW'(wgray_sync)))) << LOG_C;
    r_avail         = wptr_sync_lanes - rptr_d;
    empty_d         = r_avail < PW'(RR);
    r_cnt_d         = RCW'(r_avail >> LOG_RR);
    data_o_d        = pop_c ? rd_word_c : data_o_q;
  end

  always_ff @(posedge clk_r) begin
    if (!rst_n) begin
      rptr_q   <= '0;
      rgray_q  <= '0;
      empty_q  <= 1'b1;
      r_cnt_q  <= '0;
      data_o_q <= '0;
    end else begin
      rptr_q   <= rptr_d;
      rgray_q  <= rgray_d;
      empty_q  <= empty_d;
      r_cnt_q  <= r_cnt_d;
      data_o_q <= data_o_d;
    end
  end

  // ---------------- pointer crossings ----------------
  fifo_gray_sync #(.W(CW), .STAGES(SYNC_STAGES)) u_sync_r2w (
    .clk   (clk_w),
    .rst_n (rst_n),
    .d_i   (rgray_q),
    .q_o   (rgray_sync)
  );

  fifo_gray_sync #(.W(CW), .STAGES(SYNC_STAGES)) u_sync_w2r (
    .clk   (clk_r),
    .rst_n (rst_n),
    .d_i   (wgray_q),
    .q_o   (wgray_sync)
  );

  assign full   = full_q;
  assign empty  = empty_q;
  assign w_cnt  = w_cnt_q;
  assign r_cnt  = r_cnt_q;
  assign data_o = data_o_q;

`ifdef FIFO_ASYNC_WC_ERR_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  always_comb begin
    ovf_d = ovf_q || (w_req && full_q);
    udf_d = udf_q || (r_req && empty_q);
  end

  always_ff @(posedge clk_w) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  always_ff @(posedge clk_r) begin
    if (!rst_n) udf_q <= 1'b0;
    else        udf_q <= udf_d;
  end

  assign ovf = ovf_q;
  assign udf = udf_q;
`endif

endmodule

// File: tb/tb_fifo_async_wc.sv
// Directed + random scoreboard bench for fifo_async_wc: 64->32 (A) and 32->64 (B) instances.
`timescale 1ns/100ps
module tb_fifo_async_wc;

  logic clk_w = 1'b0;
  logic clk_r = 1'b0;
  logic rst_n = 1'b0;

  always #5    clk_w = ~clk_w;
  always #13.5 clk_r = ~clk_r;

  logic        w_req_a = 1'b0, r_req_a = 1'b0;
  logic [63:0] data_i_a = '0;
  logic [31:0] data_o_a;
  logic        full_a, empty_a;
  logic [3:0]  w_cnt_a;
  logic [4:0]  r_cnt_a;

  logic        w_req_b = 1'b0, r_req_b = 1'b0;
  logic [31:0] data_i_b = '0;
  logic [63:0] data_o_b;
  logic        full_b, empty_b;
  logic [4:0]  w_cnt_b;
  logic [3:0]  r_cnt_b;

`ifdef FIFO_ASYNC_WC_ERR_EN
  logic ovf_a, udf_a, ovf_b, udf_b;
`endif

  fifo_async_wc #(.DW_W(64), .DW_R(32), .SIZE(64), .SYNC_STAGES(2)) u_dut_a (
    .clk_w  (clk_w),
    .clk_r  (clk_r),
    .rst_n  (rst_n),
    .w_req  (w_req_a),
    .data_i (data_i_a),
    .full   (full_a),
    .r_req  (r_req_a),
    .data_o (data_o_a),
    .empty  (empty_a),
    .w_cnt  (w_cnt_a),
    .r_cnt  (r_cnt_a)
`ifdef FIFO_ASYNC_WC_ERR_EN
    ,
    .ovf    (ovf_a),
    .udf    (udf_a)
`endif
  );

  fifo_async_wc #(.DW_W(32), .DW_R(64), .SIZE(64), .SYNC_STAGES(2)) u_dut_b (
    .clk_w  (clk_w),
    .clk_r  (clk_r),
    .rst_n  (rst_n),
    .w_req  (w_req_b),
    .data_i (data_i_b),
    .full   (full_b),
    .r_req  (r_req_b),
    .data_o (data_o_b),
    .empty  (empty_b),
    .w_cnt  (w_cnt_b),
    .r_cnt  (r_cnt_b)
`ifdef FIFO_ASYNC_WC_ERR_EN
    ,
    .ovf    (ovf_b),
    .udf    (udf_b)
`endif
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] qa [$];
  logic [63:0] qb [$];
  logic [31:0] b_lo = '0;
  bit          b_half = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected lanes of a 64-bit push pop LSB-first as two 32-bit words.
  task automatic push_a(input logic [63:0] d);
    int n = 0;
    @(negedge clk_w);
    while (full_a && n < 400) begin @(negedge clk_w); n++; end
    if (full_a) begin chk("push_a_timeout", 64'd0, 64'd1); return; end
    w_req_a  = 1'b1;
    data_i_a = d;
    qa.push_back(d[31:0]);
    qa.push_back(d[63:32]);
    @(negedge clk_w);
    w_req_a = 1'b0;
  endtask

  // Two 32-bit pushes form one 64-bit pop; first push is the low half.
  task automatic push_b(input logic [31:0] d);
    int n = 0;
    @(negedge clk_w);
    while (full_b && n < 400) begin @(negedge clk_w); n++; end
    if (full_b) begin chk("push_b_timeout", 64'd0, 64'd1); return; end
    w_req_b  = 1'b1;
    data_i_b = d;
    if (!b_half) begin b_lo = d; b_half = 1'b1; end
    else begin qb.push_back({d, b_lo}); b_half = 1'b0; end
    @(negedge clk_w);
    w_req_b = 1'b0;
  endtask

  task automatic pop_a(input string tag);
    int n = 0;
    logic [31:0] exp;
    @(negedge clk_r);
    while (empty_a && n < 400) begin @(negedge clk_r); n++; end
    if (empty_a) begin chk({tag, "_timeout"}, 64'd0, 64'd1); return; end
    if (qa.size() == 0) begin chk({tag, "_spurious"}, 64'd0, 64'd1); return; end
    r_req_a = 1'b1;
    @(negedge clk_r);
    r_req_a = 1'b0;
    exp = qa.pop_front();
    chk(tag, 64'(data_o_a), 64'(exp));
  endtask

  task automatic pop_b(input string tag);
    int n = 0;
    logic [63:0] exp;
    @(negedge clk_r);
    while (empty_b && n < 400) begin @(negedge clk_r); n++; end
    if (empty_b) begin chk({tag, "_timeout"}, 64'd0, 64'd1); return; end
    if (qb.size() == 0) begin chk({tag, "_spurious"}, 64'd0, 64'd1); return; end
    r_req_b = 1'b1;
    @(negedge clk_r);
    r_req_b = 1'b0;
    exp = qb.pop_front();
    chk(tag, data_o_b, exp);
  endtask

  initial begin
    #800us;
    $display("FAIL watchdog expired observed=hang expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    int n;

    // Reset state
    rst_n = 1'b0;
    repeat (5) @(negedge clk_r);
    rst_n = 1'b1;
    @(negedge clk_w);
    chk("rst_full_a",  64'(full_a),  64'd0);
    chk("rst_empty_a", 64'(empty_a), 64'd1);
    chk("rst_wcnt_a",  64'(w_cnt_a), 64'd0);
    chk("rst_rcnt_a",  64'(r_cnt_a), 64'd0);
    chk("rst_dout_a",  64'(data_o_a), 64'd0);
    chk("rst_full_b",  64'(full_b),  64'd0);
    chk("rst_empty_b", 64'(empty_b), 64'd1);
    chk("rst_dout_b",  data_o_b,     64'd0);

    // Fill A to capacity: 8 wide words
    for (int i = 0; i < 8; i++) push_a({32'hA000_0000 + 32'(i), 32'h5000_0000 + 32'(i)});
    chk("fill_full_a", 64'(full_a),  64'd1);
    chk("fill_wcnt_a", 64'(w_cnt_a), 64'd8);
`ifdef FIFO_ASYNC_WC_ERR_EN
    chk("ovf_clear_a", 64'(ovf_a), 64'd0);
`endif
    // Push on full is dropped
    @(negedge clk_w);
    w_req_a  = 1'b1;
    data_i_a = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge clk_w);
    w_req_a = 1'b0;
    chk("drop_wcnt_a", 64'(w_cnt_a), 64'd8);
    chk("drop_full_a", 64'(full_a),  64'd1);
`ifdef FIFO_ASYNC_WC_ERR_EN
    chk("ovf_set_a", 64'(ovf_a), 64'd1);
`endif
    repeat (6) @(negedge clk_r);
    chk("full_rcnt_a",  64'(r_cnt_a), 64'd16);
    chk("full_empty_a", 64'(empty_a), 64'd0);

    for (int i = 0; i < 16; i++) pop_a("drain_a");
    chk("drain_empty_a", 64'(empty_a), 64'd1);
    chk("drain_rcnt_a",  64'(r_cnt_a), 64'd0);

    // Pop on empty leaves data_o and count alone
    held = data_o_a;
    @(negedge clk_r);
    r_req_a = 1'b1;
    @(negedge clk_r);
    r_req_a = 1'b0;
    chk("udf_dout_a", 64'(data_o_a), 64'(held));
    chk("udf_rcnt_a", 64'(r_cnt_a),  64'd0);
`ifdef FIFO_ASYNC_WC_ERR_EN
    chk("udf_set_a", 64'(udf_a), 64'd1);
`endif
    repeat (6) @(negedge clk_w);
    chk("freed_full_a", 64'(full_a),  64'd0);
    chk("freed_wcnt_a", 64'(w_cnt_a), 64'd0);

    // Wide-to-narrow lane order
    push_a(64'h1111_2222_3333_4444);
    pop_a("split_lo_a");
    chk("split_lo_const", 64'(data_o_a), 64'h3333_4444);
    pop_a("split_hi_a");
    chk("split_hi_const", 64'(data_o_a), 64'h1111_2222);
    chk("split_empty_a", 64'(empty_a), 64'd1);

    // Narrow-to-wide: half word stays invisible
    push_b(32'hAAAA_0001);
    repeat (8) @(negedge clk_r);
    chk("half_empty_b", 64'(empty_b), 64'd1);
    chk("half_rcnt_b",  64'(r_cnt_b), 64'd0);
    push_b(32'hBBBB_0002);
    chk("pair_wcnt_b", 64'(w_cnt_b), 64'd2);
    n = 0;
    while (empty_b && n < 8) begin @(negedge clk_r); n++; end
    chk("pair_latency_b", 64'(n <= 4), 64'd1);
    chk("pair_rcnt_b",    64'(r_cnt_b), 64'd1);
    pop_b("pair_b");
    chk("pair_const_b", data_o_b, 64'hBBBB_0002_AAAA_0001);

    // Random concurrent traffic on both instances, many pointer wraps
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk_w);
          push_a({$urandom, $urandom});
        end
      end
      begin
        for (int i = 0; i < 800; i++) begin
          if ($urandom_range(0, 3) == 0) @(negedge clk_r);
          pop_a("rand_a");
        end
      end
      begin
        for (int i = 0; i < 400; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk_w);
          push_b($urandom);
        end
      end
      begin
        for (int i = 0; i < 200; i++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk_r);
          pop_b("rand_b");
        end
      end
    join
    repeat (6) @(negedge clk_r);
    chk("rand_empty_a", 64'(empty_a), 64'd1);
    chk("rand_empty_b", 64'(empty_b), 64'd1);

    // Reset mid-stream discards in-flight data
    for (int i = 0; i < 3; i++) push_a({32'hC000_0000 + 32'(i), 32'hD000_0000 + 32'(i)});
    push_b(32'h1234_5678);
    @(negedge clk_r);
    rst_n = 1'b0;
    repeat (4) @(negedge clk_r);
    rst_n = 1'b1;
    qa.delete();
    qb.delete();
    b_half = 1'b0;
    @(negedge clk_w);
    chk("mrst_full_a",  64'(full_a),   64'd0);
    chk("mrst_empty_a", 64'(empty_a),  64'd1);
    chk("mrst_wcnt_a",  64'(w_cnt_a),  64'd0);
    chk("mrst_rcnt_a",  64'(r_cnt_a),  64'd0);
    chk("mrst_dout_a",  64'(data_o_a), 64'd0);
    chk("mrst_wcnt_b",  64'(w_cnt_b),  64'd0);
    chk("mrst_empty_b", 64'(empty_b),  64'd1);
`ifdef FIFO_ASYNC_WC_ERR_EN
    chk("mrst_ovf_a", 64'(ovf_a), 64'd0);
    chk("mrst_udf_a", 64'(udf_a), 64'd0);
`endif
    push_a(64'h0BAD_F00D_CAFE_1234);
    pop_a("post_rst_lo_a");
    pop_a("post_rst_hi_a");
    push_b(32'h0000_00AA);
    push_b(32'h0000_00BB);
    pop_b("post_rst_b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_async_wc.md
Name: fifo_async_wc

Overview:
Synthesisable dual-clock FIFO with write/read width conversion. It is the hardware successor to the DPI-modelled async FIFO and uses the same byte-sized SIZE budget.
- Gray-coded pointers cross clock domains through synchroniser chains.
- Supports power-of-two width ratios in either direction (wide-to-narrow or narrow-to-wide).
- Sits between producer/consumer blocks that run in unrelated clock domains.

Parameters:
DW_W, 64, write data width in bits; power of two, ≥8.
DW_R, 32, read data width in bits; power of two, ≥8; max(DW_W,DW_R)/min(DW_W,DW_R) ≤ 16.
SIZE, 2048, capacity in bytes; SIZE*8/max(DW_W,DW_R) must be a power of two, ≥2.
SYNC_STAGES, 2, synchroniser flops per crossing pointer (2..4).

Ports:
clk_w  in  1  write clock
clk_r  in  1  read clock
rst_n  in  1  synchronous active-low reset, sampled in both domains
w_req  in  1  push request
data_i  in  DW_W  push data
full  out  1  no room for one DW_W word
r_req  in  1  pop request
data_o  out  DW_R  pop data (registered)
empty  out  1  fewer than DW_R bits readable
w_cnt  out  clog2(SIZE*8/DW_W)+1  occupancy in DW_W words, write-domain view
r_cnt  out  clog2(SIZE*8/DW_R)+1  occupancy in DW_R words, read-domain view

Behaviour:
- Reset: rst_n is synchronous, active-low; the primary clock is clk_w. rst_n is also sampled synchronously on clk_r.
  - rst_n must be held low for ≥ SYNC_STAGES+1 cycles of the slower clock.
  - Reset values: full=0, empty=1, w_cnt=0, r_cnt=0, data_o=0. All pointers and synchroniser flops are cleared.
  - Storage is not cleared.
- Derived constants: DW_N = min(DW_W,DW_R); RW = DW_W/DW_N; RR = DW_R/DW_N; LOG_C = log2(max(RW,RR)).
  - DEPTH_N = SIZE*8/DW_N (narrow lanes). DEPTH_C = DEPTH_N>>LOG_C (coarse words).
- Storage: DEPTH_N lanes of DW_N bits, packed LSB-first.
  - A wide word's bits [DW_N-1:0] occupy the lowest lane and are popped first by a narrow reader.
  - A narrow writer fills lanes LSB-first into the wide word.
- Pointers: each side keeps a binary pointer in lanes, width log2(DEPTH_N)+1.
  - Each side publishes gray(ptr>>LOG_C), width log2(DEPTH_C)+1, from a register. This published value changes by exactly one bit per coarse word.
- Full: asserted when DEPTH_N − (wptr − (rptr_sync<<LOG_C)) < RW. Registered, updated every clk_w.
- Empty: asserted when ((wptr_sync<<LOG_C) − rptr) < RR. Registered, updated every clk_r.
  - A partially filled coarse word (narrow writer) is invisible to the reader until complete.
- Push: w_req && !full → write data_i at wptr, wptr += RW. w_req while full is ignored; no pointer or storage change.
- Pop: r_req && !empty → data_o loads the lanes at rptr on the next clk_r edge, and rptr += RR. data_o holds otherwise.
  - r_req while empty is ignored and data_o holds.
- Latency:
  - A push completing a coarse word clears empty within SYNC_STAGES+2 clk_r edges.
  - A pop freeing a coarse word clears full within SYNC_STAGES+2 clk_w edges.
  - Both flags are pessimistic, never optimistic.
- Counts: w_cnt = (wptr − (rptr_sync<<LOG_C))/RW. r_cnt = ((wptr_sync<<LOG_C) − rptr)/RR. Both are floor values and registered.
- Wrap-around: pointers wrap modulo 2·DEPTH_N. The MSB distinguishes full from empty.
- Simultaneous push and pop: fully independent. No combinational path between domains.
- Reset mid-operation: all in-flight data is discarded. The block returns to reset state within the reset window.

Optional Feature:
Macro FIFO_ASYNC_WC_ERR_EN.
- Defined: adds outputs ovf (clk_w domain) and udf (clk_r domain).
  - ovf is sticky-set the cycle after w_req&&full.
  - udf is sticky-set the cycle after r_req&&empty.
  - Both clear only on reset.
- Undefined: the ports and their logic are absent. Behaviour is otherwise identical.

Decomposition:
- Package fifo_async_pkg: clog2 function, bin2gray/gray2bin functions, ratio/depth derivation helpers.
- Sub-module fifo_gray_sync: a SYNC_STAGES flop chain for a gray vector. Parameterised width. It has its own clock and sync reset. Instantiated twice.

Test Plan:
- Instance DW_W=64, DW_R=32, SIZE=64, clk_w 100 MHz, clk_r 37 MHz. Push 8 words → full=1 after the 8th, w_cnt=8. A 9th push is dropped (ovf=1 with macro).
- Same instance: push 0x1111_2222_3333_4444 → pops return 0x33334444 then 0x11112222. Empty=1 after the 2nd pop.
- Reverse instance DW_W=32, DW_R=64, SIZE=64: push 0xAAAA0001 → empty stays 1. Push 0xBBBB0002 → empty=0 within 4 clk_r edges; pop yields 0xBBBB0002_AAAA0001.
- Random concurrent push/pop, 10k words, ratios 1, 2, 4 each direction → scoreboard matches, no loss or duplication, ≥3 pointer wraps.
- Pop on empty and push on full → data_o unchanged, counts unchanged. udf/ovf set only with FIFO_ASYNC_WC_ERR_EN.
- Assert rst_n mid-stream for 4 slow-clock cycles → full=0, empty=1, counts 0. The next pushed word is the next popped word.
